// File: rtl/lc3b_memif.sv
// LC-3b memory interface. Accepts one request at a time and completes it after
// a fixed latency. Word or byte writes and full-word reads go to a local array
// of 16-bit words.
module lc3b_memif #(
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mio_en,
  input  logic              r_w,
  input  logic              data_size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata,
  output logic              r,
  output logic              err,
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W:0]   addr_q;    // word index plus the byte-select bit
  logic             rw_q;
  logic             size_q;
  logic [15:0]      wdata_q;
  logic             err_q;

  logic [15:0]      mem [DEPTH];

  logic             accept;
  logic             exec;
  logic             misaligned;
  logic [IDX_W-1:0] word_idx;

  // Address bits above the word index only alias; they are dropped on purpose.
  if (IDX_W + 1 < ADDR_W) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[ADDR_W-1:IDX_W+1];
  end

  assign accept     = (state == IDLE) && mio_en;
  assign exec       = (state == WAIT) && (cnt == '0);
  assign misaligned = size_q && addr_q[0];
  assign word_idx   = addr_q[IDX_W:1];

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Next-state logic: mio_en only matters in IDLE.
  // NOTE: combinational outputs get a default first so no path infers a latch.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (mio_en) state_n = WAIT;
      WAIT:    if (cnt == '0) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output decode: ready pulse in DONE, error qualified by ready.
  always_comb begin
    r    = (state == DONE);
    busy = (state != IDLE);
    err  = (state == DONE) && err_q;
  end

  // Request capture, latency counter, error flag and read-data register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      size_q  <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata   <= '0;
    end else begin
      if (accept) begin
        addr_q  <= addr[IDX_W:0];
        rw_q    <= r_w;
        size_q  <= data_size;
        wdata_q <= wdata;
        cnt     <= CNT_W'(WAIT_CYCLES - 1);
      end else if ((state == WAIT) && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (exec) begin
        err_q <= misaligned;
        if (!rw_q && !misaligned) rdata <= mem[word_idx];
      end
    end
  end

  // Storage array write port with per-byte lanes.
  // NOTE: the array is deliberately left out of reset; its contents are
  // undefined until written and resetting it would defeat RAM inference.
  always_ff @(posedge clk) begin
    if (exec && rw_q && !misaligned) begin
      if (size_q)         mem[word_idx]       <= wdata_q;
      else if (addr_q[0]) mem[word_idx][15:8] <= wdata_q[15:8];
      else                mem[word_idx][7:0]  <= wdata_q[7:0];
    end
  end

endmodule

// File: tb/tb_lc3b_memif.sv
// Directed bench for lc3b_memif: a behavioural memory model predicts each
// access's rdata/err into a scoreboard queue, popped when the ready pulse shows.
module tb_lc3b_memif;

  localparam int ADDR_W      = 16;
  localparam int DEPTH       = 1024;
  localparam int WAIT_CYCLES = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mio_en;
  logic        r_w;
  logic        data_size;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        r;
  logic        err;
  logic        busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb [$];
  logic [15:0] mem_m [DEPTH];
  logic [15:0] rdata_m = 16'h0000;

  always #5 clk = ~clk;

  lc3b_memif #(
    .ADDR_W      (ADDR_W),
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mio_en    (mio_en),
    .r_w       (r_w),
    .data_size (data_size),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .r         (r),
    .err       (err),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one access; pushes what the ready cycle must show.
  function automatic void predict(input logic rw, input logic sz,
                                  input logic [15:0] a, input logic [15:0] wd);
    int idx;
    logic mis;
    idx = int'(a[15:1]) % DEPTH;
    mis = sz & a[0];
    if (!mis) begin
      if (rw) begin
        if (sz)        mem_m[idx]       = wd;
        else if (a[0]) mem_m[idx][15:8] = wd[15:8];
        else           mem_m[idx][7:0]  = wd[7:0];
      end else begin
        rdata_m = mem_m[idx];
      end
    end
    sb.push_back('{rdata: rdata_m, err: mis});
  endfunction

  task automatic issue(input logic rw, input logic sz, input logic [15:0] a,
                       input logic [15:0] wd);
    mio_en    = 1'b1;
    r_w       = rw;
    data_size = sz;
    addr      = a;
    wdata     = wd;
    predict(rw, sz, a, wd);
  endtask

  // One isolated access, called and returning just after a falling edge.
  task automatic access(input string tag, input logic rw, input logic sz,
                        input logic [15:0] a, input logic [15:0] wd);
    int   n;
    exp_t e;
    issue(rw, sz, a, wd);
    @(posedge clk);
    @(negedge clk);
    // Scramble the inputs: the captured request must be what executes.
    mio_en    = 1'b0;
    r_w       = ~rw;
    data_size = ~sz;
    addr      = ~a;
    wdata     = ~wd;
    check1({tag, "/busy"}, busy, 1'b1);
    n = 0;
    while (r !== 1'b1 && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check({tag, "/latency"}, 16'(n), 16'(WAIT_CYCLES));
    if (r === 1'b1) begin
      e = sb.pop_front();
      check1({tag, "/err"}, err, e.err);
      check({tag, "/rdata"}, rdata, e.rdata);
    end
    @(posedge clk);
    @(negedge clk);
    check1({tag, "/r_low"}, r, 1'b0);
    check1({tag, "/err_low"}, err, 1'b0);
    check1({tag, "/idle"}, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   pulses;
    int   cyc;
    int   last;
    int   idle;
    logic r_seen;
    exp_t e;

    rst       = 1'b0;
    mio_en    = 1'b0;
    r_w       = 1'b0;
    data_size = 1'b0;
    addr      = '0;
    wdata     = '0;
    #2;
    check1("rst/r", r, 1'b0);
    check1("rst/err", err, 1'b0);
    check1("rst/busy", busy, 1'b0);
    check("rst/rdata", rdata, 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Word write then read back.
    access("w1234", 1'b1, 1'b1, 16'h0010, 16'h1234);
    access("r0010", 1'b0, 1'b1, 16'h0010, 16'h0000);

    // Byte writes to each lane; a byte read returns the full word.
    access("bhi", 1'b1, 1'b0, 16'h0011, 16'hABAB);
    access("r_ab34", 1'b0, 1'b1, 16'h0010, 16'h0000);
    access("blo", 1'b1, 1'b0, 16'h0010, 16'hCDCD);
    access("rb_abcd", 1'b0, 1'b0, 16'h0011, 16'h0000);

    // Misaligned word write: err with r, memory and rdata untouched.
    access("w0012", 1'b1, 1'b1, 16'h0012, 16'h0000);
    access("mis_w", 1'b1, 1'b1, 16'h0013, 16'h5555);
    access("r0012", 1'b0, 1'b1, 16'h0012, 16'h0000);
    access("mis_r", 1'b0, 1'b1, 16'h0011, 16'h0000);
    access("b_odd", 1'b1, 1'b0, 16'h0013, 16'h9900);
    access("r9900", 1'b0, 1'b1, 16'h0012, 16'h0000);

    // Aliasing: index 0x408 wraps to 8.
    access("wrap_w", 1'b1, 1'b1, 16'h0810, 16'hBEEF);
    access("wrap_r", 1'b0, 1'b1, 16'h0010, 16'h0000);

    // Reset during WAIT aborts a write; rdata clears; the old word survives.
    access("w2222", 1'b1, 1'b1, 16'h0020, 16'h2222);
    mio_en    = 1'b1;
    r_w       = 1'b1;
    data_size = 1'b1;
    addr      = 16'h0020;
    wdata     = 16'h7777;
    @(posedge clk);
    @(negedge clk);
    mio_en = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    rdata_m = 16'h0000;
    #1;
    check1("abort/busy", busy, 1'b0);
    check1("abort/r", r, 1'b0);
    check("abort/rdata", rdata, 16'h0000);
    r_seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      r_seen = r_seen | r;
    end
    check1("abort/no_r", r_seen, 1'b0);
    rst = 1'b1;
    access("abort_rd", 1'b0, 1'b1, 16'h0020, 16'h0000);

    // Back-to-back reads with mio_en held high.
    issue(1'b0, 1'b1, 16'h0010, 16'h0000);
    pulses = 0;
    cyc    = 0;
    last   = 0;
    idle   = 0;
    while (pulses < 3 && cyc < 100) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (!busy) idle++;
      if (r === 1'b1) begin
        pulses++;
        e = sb.pop_front();
        check1($sformatf("b2b%0d/err", pulses), err, e.err);
        check($sformatf("b2b%0d/rdata", pulses), rdata, e.rdata);
        if (pulses > 1) begin
          check($sformatf("b2b%0d/gap", pulses), 16'(cyc - last), 16'(WAIT_CYCLES + 2));
          check($sformatf("b2b%0d/idle", pulses), 16'(idle), 16'd1);
        end
        last = cyc;
        idle = 0;
        if (pulses == 1)      issue(1'b0, 1'b1, 16'h0012, 16'h0000);
        else if (pulses == 2) issue(1'b0, 1'b1, 16'h0810, 16'h0000);
        else                  mio_en = 1'b0;
      end
    end
    check("b2b/pulses", 16'(pulses), 16'd3);
    check("sb/empty", 16'(sb.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lc3b_memif.md
LC3B_MEMIF -- requirements
Module: lc3b_memif

Interface
REQ-001 Parameter ADDR_W, default 16, SHALL set the byte-address width.
REQ-002 Parameter DEPTH, default 1024, SHALL set the number of 16-bit words stored; legal only as a power of two no greater than 2^(ADDR_W-1).
REQ-003 Parameter WAIT_CYCLES, default 4, SHALL set the access latency; legal only when at least 1.
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-006 Port mio_en, input, 1 bit, SHALL be the memory request strobe.
REQ-007 Port r_w, input, 1 bit, SHALL select the access type: 1 = write, 0 = read.
REQ-008 Port data_size, input, 1 bit, SHALL select the access size: 1 = word, 0 = byte.
REQ-009 Port addr, input, ADDR_W bits, SHALL carry the byte address (MAR).
REQ-010 Port wdata, input, 16 bits, SHALL carry the write data (MDR).
REQ-011 Port rdata, output, 16 bits, SHALL return the read word.
REQ-012 Port r, output, 1 bit, SHALL be the ready pulse marking access completion.
REQ-013 Port err, output, 1 bit, SHALL flag an unaligned word access and is valid only while r=1.
REQ-014 Port busy, output, 1 bit, SHALL be high whenever the state is not IDLE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, WAIT and DONE.
REQ-016 IDLE->WAIT SHALL occur on an edge with mio_en=1, capturing addr, r_w, data_size and wdata, and loading cnt=WAIT_CYCLES-1.
REQ-017 In WAIT with cnt!=0, cnt SHALL decrement; with cnt==0, the access SHALL execute on that edge and the state SHALL become DONE.
REQ-018 DONE->IDLE SHALL be unconditional; mio_en is ignored in WAIT and DONE.
REQ-019 Latency: with acceptance at edge t0, r SHALL be high for exactly the one cycle following edge t0+WAIT_CYCLES.
REQ-020 Captured fields SHALL be used for the whole access; input changes after acceptance, including mio_en falling, SHALL have no effect.
REQ-021 Word index SHALL be addr[ADDR_W-1:1] modulo DEPTH, so out-of-range addresses wrap and alias.
REQ-022 A word write SHALL store the full 16-bit wdata.
REQ-023 A byte write with addr[0]=0 SHALL update the low byte from wdata[7:0] only; with addr[0]=1 it SHALL update the high byte from wdata[15:8] only.
REQ-024 A read of either size SHALL load the full addressed word into rdata on the execute edge; byte selection and sign extension belong to the datapath.
REQ-025 rdata SHALL hold its value until the next successful read executes.
REQ-026 For a word access with addr[0]=1, err SHALL be 1 in DONE, memory SHALL be unmodified and rdata SHALL be unchanged.
REQ-027 err SHALL be 0 whenever r=0.
REQ-028 Holding mio_en high continuously SHALL produce back-to-back accesses with r pulses spaced exactly WAIT_CYCLES+2 cycles apart.

Reset
REQ-029 rst=0 SHALL immediately force state=IDLE, cnt=0, r=0, err=0, busy=0 and rdata=16'h0000, independent of clk.
REQ-030 A reset asserted during WAIT SHALL abort the access with no memory write and no r pulse.
REQ-031 Memory array contents SHALL NOT be reset; they are undefined until written.
REQ-032 The first request after reset deassertion SHALL be accepted on the first rising edge with rst=1 and mio_en=1.

Verification (defaults: WAIT_CYCLES=4, DEPTH=1024)
REQ-033 Word write 0x1234 @0x0010, then word read @0x0010 -> rdata=0x1234, r high one cycle, 4 edges after acceptance, err=0.
REQ-034 Word 0x1234 @0x0010, then byte write wdata=0xABAB @0x0011 -> word read @0x0010 returns 0xAB34.
REQ-035 Word write 0x5555 @0x0013 with prior 0x0000 @0x0012 -> err=1 with r; read @0x0012 returns 0x0000.
REQ-036 Word write 0xBEEF @0x0810 -> word read @0x0010 returns 0xBEEF (wrap at index 8).
REQ-037 Word write 0x7777 @0x0020 with rst pulsed low in the second WAIT cycle -> no r, busy=0; read @0x0020 returns the prior value.
REQ-038 mio_en held high for three reads -> three r pulses exactly 6 cycles apart, busy low one cycle between accesses.
